ofm_accumulator: RTL



---
 rtl/ofm_accumulator.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ofm_accumulator.sv
// Accumulates PE-array partial sums over CI channels into an OFM buffer, then drains each finished
// map over valid/ready for CO filters. Define SATURATE_EN for clamping accumulation (default wraps).
module ofm_accumulator #(
    parameter int KERNEL_SIZE = 4,
    parameter int IFM_SIZE    = 9,
    parameter int CI          = 3,
    parameter int CO          = 4,
    parameter int DATA_W      = 16,
    parameter int ACC_W       = 32
) (
    input  logic                     clk1,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     psum_valid,
    input  logic signed [DATA_W-1:0] psum_data,
    output logic                     psum_ready,
    output logic                     ofm_valid,
    output logic signed [ACC_W-1:0]  ofm_data,
    output logic                     ofm_last,
    input  logic                     ofm_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int OFM_SIZE = IFM_SIZE - KERNEL_SIZE + 1;
    localparam int NPIX     = OFM_SIZE * OFM_SIZE;
    localparam int PIX_W    = $clog2(NPIX + 1);
    localparam int IDX_W    = $clog2(NPIX);
    localparam int CH_W     = $clog2(CI + 1);
    localparam int FL_W     = $clog2(CO + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [PIX_W-1:0]          r_pix;
    logic [PIX_W-1:0]          r_rd;
    logic [CH_W-1:0]           r_chan;
    logic [FL_W-1:0]           r_filt;
    logic signed [ACC_W-1:0]   r_buf [NPIX];
    logic                      r_psum_ready;
    logic                      r_ofm_valid;
    logic signed [ACC_W-1:0]   r_ofm_data;
    logic                      r_ofm_last;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_accept;
    logic                      w_pix_end;
    logic                      w_chan_end;
    logic                      w_filt_end;
    logic                      w_fire;
    logic                      w_load;
    logic                      w_last_fire;
    logic [IDX_W-1:0]          w_wr_idx;
    logic [IDX_W-1:0]          w_rd_idx;
    logic signed [ACC_W-1:0]   w_psum_ext;
    logic signed [ACC_W-1:0]   w_acc_val;

    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
`ifdef SATURATE_EN
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            if (s[ACC_W]) begin
                acc_add = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                acc_add = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            acc_add = s[ACC_W-1:0];
        end
`else
        acc_add = a + b;
`endif
    endfunction

    assign psum_ready  = r_psum_ready;
    assign ofm_valid   = r_ofm_valid;
    assign ofm_data    = r_ofm_data;
    assign ofm_last    = r_ofm_last;
    assign busy        = r_busy;
    assign done        = r_done;

    assign w_accept    = psum_valid & r_psum_ready;
    assign w_pix_end   = (r_pix == PIX_W'(NPIX - 1));
    assign w_chan_end  = (r_chan == CH_W'(CI - 1));
    assign w_filt_end  = (r_filt == FL_W'(CO - 1));
    assign w_fire      = r_ofm_valid & ofm_ready;
    assign w_last_fire = w_fire & r_ofm_last;
    // The output register refills whenever it is empty or being taken, so drain runs at one pixel per cycle.
    assign w_load      = (r_state == S_DRAIN) && (r_rd != PIX_W'(NPIX)) && (!r_ofm_valid || ofm_ready);
    assign w_wr_idx    = r_pix[IDX_W-1:0];
    assign w_rd_idx    = r_rd[IDX_W-1:0];
    assign w_psum_ext  = ACC_W'(psum_data);

    // Accumulate value: channel 0 overwrites stale contents, later channels add into the buffer.
    always_comb begin
        w_acc_val = w_psum_ext;
        if (r_chan == {CH_W{1'b0}}) begin
            w_acc_val = w_psum_ext;
        end else begin
            w_acc_val = acc_add(r_buf[w_wr_idx], w_psum_ext);
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_ACCUM;
                else       w_next = S_IDLE;
            end
            S_ACCUM: begin
                if (w_accept && w_pix_end && w_chan_end) w_next = S_DRAIN;
                else                                     w_next = S_ACCUM;
            end
            S_DRAIN: begin
                if (w_last_fire) begin
                    if (w_filt_end) w_next = S_DONE;
                    else            w_next = S_ACCUM;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // OFM buffer write port; contents are meaningless until channel 0 of a filter has been written.
    always_ff @(posedge clk1) begin
        if (w_accept) begin
            r_buf[w_wr_idx] <= w_acc_val;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pix        <= {PIX_W{1'b0}};
            r_rd         <= {PIX_W{1'b0}};
            r_chan       <= {CH_W{1'b0}};
            r_filt       <= {FL_W{1'b0}};
            r_psum_ready <= 1'b0;
            r_ofm_valid  <= 1'b0;
            r_ofm_data   <= {ACC_W{1'b0}};
            r_ofm_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_psum_ready <= (w_next == S_ACCUM);
            r_busy       <= (w_next == S_ACCUM) || (w_next == S_DRAIN);
            r_done       <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pix  <= {PIX_W{1'b0}};
                        r_chan <= {CH_W{1'b0}};
                        r_filt <= {FL_W{1'b0}};
                        r_rd   <= {PIX_W{1'b0}};
                    end
                end
                S_ACCUM: begin
                    r_rd <= {PIX_W{1'b0}};
                    if (w_accept) begin
                        if (w_pix_end) begin
                            r_pix <= {PIX_W{1'b0}};
                            if (w_chan_end) r_chan <= {CH_W{1'b0}};
                            else            r_chan <= r_chan + CH_W'(1);
                        end else begin
                            r_pix <= r_pix + PIX_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_load) begin
                        r_ofm_data  <= r_buf[w_rd_idx];
                        r_ofm_last  <= (r_rd == PIX_W'(NPIX - 1));
                        r_ofm_valid <= 1'b1;
                        r_rd        <= r_rd + PIX_W'(1);
                    end else if (w_fire) begin
                        r_ofm_valid <= 1'b0;
                        r_ofm_last  <= 1'b0;
                    end
                    if (w_last_fire) begin
                        r_rd <= {PIX_W{1'b0}};
                        if (!w_filt_end) r_filt <= r_filt + FL_W'(1);
                    end
                end
                S_DONE: begin
                    r_filt <= {FL_W{1'b0}};
                end
                default: begin
                    r_pix <= {PIX_W{1'b0}};
                end
            endcase
        end
    end

endmodule
